// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Data-memory / MMIO initiator sitting between the MEM stage and a
//            word-only memory. Converts byte/half/word loads and stores into
//            word transactions. Sub-word stores to RAM use read-modify-write.
//            Stores to the IO window are written directly and zero-extended.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready/req_we/req_size/req_sign/req_addr/req_wdata
//                                          - request handshake and fields
//            rsp_valid/rsp_rdata/rsp_err   - completion pulse, load data, error
//            mem_addr/mem_we/mem_wdata/mem_rdata - word memory port
// Config   : define MISALIGN_TRAP_EN to trap misaligned half/word accesses
//            (no memory access, rsp_err=1). Undefined: low bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_ST     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Request fields captured at accept; inputs are don't-care afterwards.
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_buf;     // merge buffer for read-modify-write
  logic [31:0] r_rdata;   // last load result, held until the next load

  logic        w_is_io;
  logic        w_misalign;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_data;
  logic [31:0] w_merge;

  assign w_is_io = (req_addr >= IO_BASE);

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (req_valid && (r_state == S_IDLE)) begin
      r_err <= w_misalign;
    end
  end

  assign rsp_err = (r_state == S_DONE) && r_err;
`else
  assign w_misalign = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_buf   <= '0;
      r_rdata <= '0;
    end else begin
      if (req_valid && (r_state == S_IDLE)) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_sign  <= req_sign;
      end
      if (r_state == S_RMW_RD) begin
        r_buf <= mem_rdata;
      end
      if (r_state == S_LD) begin
        r_rdata <= w_ld_data;
      end
    end
  end

  // Little-endian lane extraction: byte lane = addr[1:0], half lane = addr[1].
  assign w_ld_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ld_data = mem_rdata;
    case (r_size)
      2'b00:   w_ld_data = {{24{r_sign & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = {{16{r_sign & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Direct store word: only word stores and IO stores get here, so a sub-word
  // size means an IO store, which is written zero-extended and unshifted.
  always_comb begin
    w_st_data = r_wdata;
    case (r_size)
      2'b00:   w_st_data = {24'h0, r_wdata[7:0]};
      2'b01:   w_st_data = {16'h0, r_wdata[15:0]};
      default: w_st_data = r_wdata;
    endcase
  end

  // Read-modify-write merge: replace the target lane in the buffered word.
  always_comb begin
    w_merge = r_buf;
    case (r_size)
      2'b00: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01: begin
        if (r_addr[1]) begin
          w_merge[31:16] = r_wdata[15:0];
        end else begin
          w_merge[15:0] = r_wdata[15:0];
        end
      end
      default: w_merge = r_wdata;
    endcase
  end

  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign rsp_rdata = r_rdata;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_misalign) begin
            w_state_nxt = S_DONE;
          end else if (!req_we) begin
            w_state_nxt = S_LD;
          end else if (req_size[1] || w_is_io) begin
            w_state_nxt = S_ST;
          end else begin
            w_state_nxt = S_RMW_RD;
          end
        end
      end
      S_LD:     w_state_nxt = S_DONE;
      S_ST: begin
        mem_we      = 1'b1;
        mem_wdata   = w_st_data;
        w_state_nxt = S_DONE;
      end
      S_RMW_RD: w_state_nxt = S_RMW_WR;
      S_RMW_WR: begin
        mem_we      = 1'b1;
        mem_wdata   = w_merge;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. Provides a word memory
//            plus an IO window (switch read value, last IO write) and keeps a
//            byte-level reference memory to predict load results and stores.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam logic [31:0] IO_BASE = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_unit #(.IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Bus-side memory: RAM words and the IO window.
  logic [31:0] ram [0:16383];
  logic [31:0] io_sw;
  logic [31:0] io_wr_data;
  int          io_wr_cnt;

  assign mem_rdata = (mem_addr >= IO_BASE) ? io_sw : ram[mem_addr[15:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr >= IO_BASE) begin
        io_wr_data = mem_wdata;
        io_wr_cnt  = io_wr_cnt + 1;
      end else begin
        ram[mem_addr[15:2]] = mem_wdata;
      end
    end
  end

  // Reference model: byte-addressed RAM image for addresses 0..0xFFF.
  logic [7:0]  refb [0:4095];
  logic [31:0] last_rdata;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a & 32'h0000_0FFC);
    return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] size, input logic sign);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sign && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (sign && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] a);
    if (!TRAP) return 1'b0;
    if (size == 2'd1) return a[0];
    if (size >= 2'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    int b;
    if (size == 2'd0) begin
      refb[int'(a[11:0])] = d[7:0];
    end else if (size == 2'd1) begin
      b = int'(a & 32'h0000_0FFE);
      refb[b] = d[7:0]; refb[b+1] = d[15:8];
    end else begin
      b = int'(a & 32'h0000_0FFC);
      refb[b] = d[7:0]; refb[b+1] = d[15:8]; refb[b+2] = d[23:16]; refb[b+3] = d[31:24];
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    int b;
    b = int'(a & 32'h0000_0FFC);
    ram[b/4] = w;
    refb[b] = w[7:0]; refb[b+1] = w[15:8]; refb[b+2] = w[23:16]; refb[b+3] = w[31:24];
  endtask

  // Issue one request and observe it to completion (bounded).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int we_cyc, output logic [31:0] rdata,
                        output logic err, output logic [31:0] addr_seen, output logic ready_ok);
    @(negedge clk);
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    ready_ok  = req_ready;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr  = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_sign  = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; we_cyc = 0; rdata = '0; err = 1'b0; addr_seen = mem_addr;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cyc++;
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got ready/valid/err/we=%b required 1000",
               {req_ready, rsp_valid, rsp_err, mem_we});
    end
    n_cmp++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h required all 0",
               rsp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    last_rdata = '0;
  endtask

  task automatic test_load_ext();
    int lat, wc; logic [31:0] rd, as; logic er, rk;
    poke(32'h10, 32'h8899_AABB);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (rd !== 32'hFFFF_FFAA || lat != 2) begin
      n_bad++; $display("FAIL lb_sign: got %h lat %0d required FFFFFFAA lat 2", rd, lat);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (rd !== 32'h0000_00AA || lat != 2 || wc != 0) begin
      n_bad++; $display("FAIL lbu: got %h lat %0d we %0d required 000000AA lat 2 we 0", rd, lat, wc);
    end
    last_rdata = rd;
  endtask

  task automatic test_rmw_store();
    int lat, wc; logic [31:0] rd, as; logic er, rk;
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_0055, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (ram[4] !== 32'h8855_AABB || lat != 3 || wc != 1) begin
      n_bad++; $display("FAIL sb_rmw: got %h lat %0d we %0d required 8855AABB lat 3 we 1", ram[4], lat, wc);
    end
    n_cmp++;
    if (rd !== last_rdata) begin
      n_bad++; $display("FAIL rdata_hold: got %h required %h", rd, last_rdata);
    end
    ref_store(32'h12, 2'd0, 32'h55);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (ram[4] !== 32'h1234_AABB || lat != 3) begin
      n_bad++; $display("FAIL sh_rmw: got %h lat %0d required 1234AABB lat 3", ram[4], lat);
    end
    ref_store(32'h12, 2'd1, 32'h1234);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (rd !== 32'h0000_1234) begin
      n_bad++; $display("FAIL lh: got %h required 00001234", rd);
    end
    last_rdata = rd;
    do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (ram[5] !== 32'hDEAD_BEEF || lat != 2 || wc != 1) begin
      n_bad++; $display("FAIL sw: got %h lat %0d we %0d required DEADBEEF lat 2 we 1", ram[5], lat, wc);
    end
    ref_store(32'h14, 2'd2, 32'hDEAD_BEEF);
  endtask

  task automatic test_io();
    int lat, wc, cnt0; logic [31:0] rd, as; logic er, rk;
    cnt0 = io_wr_cnt;
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_F060, 32'h0000_A5A5, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (io_wr_data !== 32'h0000_A5A5 || lat != 2 || io_wr_cnt != cnt0 + 1 || as !== 32'hFFFF_F060) begin
      n_bad++; $display("FAIL io_sw: got %h lat %0d addr %h required 0000A5A5 lat 2", io_wr_data, lat, as);
    end
    do_req(1'b1, 2'd0, 1'b0, 32'hFFFF_F061, 32'h0000_01FF, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (io_wr_data !== 32'h0000_00FF || lat != 2) begin
      n_bad++; $display("FAIL io_sb: got %h lat %0d required 000000FF lat 2", io_wr_data, lat);
    end
    io_sw = 32'h0012_3456;
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_F070, 32'h0, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (rd !== 32'h0012_3456 || lat != 2) begin
      n_bad++; $display("FAIL io_lw: got %h lat %0d required 00123456 lat 2", rd, lat);
    end
    last_rdata = rd;
  endtask

  task automatic test_misalign();
    int lat, wc; logic [31:0] rd, as; logic er, rk;
    do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (TRAP) begin
      if (er !== 1'b1 || wc != 0 || lat != 1 || rd !== last_rdata) begin
        n_bad++; $display("FAIL lw_mis: got err %b lat %0d rd %h required err 1 lat 1 rd %h", er, lat, rd, last_rdata);
      end
    end else begin
      if (er !== 1'b0 || rd !== 32'h1234_AABB || lat != 2) begin
        n_bad++; $display("FAIL lw_mis: got err %b lat %0d rd %h required err 0 lat 2 rd 1234AABB", er, lat, rd);
      end
      last_rdata = rd;
    end
  endtask

  task automatic test_back_to_back();
    int pulses, wes, bad_rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 32'h14; req_wdata = '0;
    pulses = 0; wes = 0; bad_rd = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) begin
        pulses++;
        if (rsp_rdata !== 32'hDEAD_BEEF) bad_rd++;
      end
      if (mem_we) wes++;
    end
    req_valid = 1'b0;
    last_rdata = 32'hDEAD_BEEF;
    n_cmp++;
    if (pulses != 4 || wes != 0 || bad_rd != 0) begin
      n_bad++; $display("FAIL b2b_load: got pulses %0d we %0d badrd %0d required 4 0 0", pulses, wes, bad_rd);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h15; req_wdata = 32'h77;
    pulses = 0; wes = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
      if (mem_we) wes++;
    end
    req_valid = 1'b0;
    ref_store(32'h15, 2'd0, 32'h77);
    n_cmp++;
    if (pulses != 3 || wes != 3 || ram[5] !== 32'hDEAD_77EF) begin
      n_bad++; $display("FAIL b2b_rmw: got pulses %0d we %0d word %h required 3 3 DEAD77EF", pulses, wes, ram[5]);
    end
  endtask

  task automatic test_random();
    int lat, wc, cnt0, elat, ewc, bad;
    logic [31:0] rd, as, a, d, exp, ew;
    logic er, rk, we, sg, io, mis;
    logic [1:0] sz;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); d = $urandom;
      io = ($urandom_range(0, 4) == 0);
      a  = io ? (IO_BASE | 32'($urandom_range(0, 32'hFFF))) : 32'($urandom_range(0, 32'hFFF));
      io_sw = $urandom;
      mis = is_mis(sz, a);
      cnt0 = io_wr_cnt;
      do_req(we, sz, sg, a, d, lat, wc, rd, er, as, rk);
      elat = mis ? 1 : (!we ? 2 : ((sz >= 2'd2 || io) ? 2 : 3));
      ewc  = (mis || !we) ? 0 : 1;
      if (!we && !mis) exp = exp_load(io ? io_sw : ref_word(a), a[1:0], sz, sg);
      else             exp = last_rdata;
      n_cmp++;
      if (rd !== exp || er !== mis || lat != elat || wc != ewc || rk !== 1'b1 || as !== {a[31:2], 2'b00}) begin
        n_bad++; bad++;
        $display("FAIL rand_rsp[%0d]: we %b sz %0d a %h got rd %h err %b lat %0d we %0d addr %h required rd %h err %b lat %0d we %0d",
                 i, we, sz, a, rd, er, lat, wc, as, exp, mis, elat, ewc);
      end
      if (!we && !mis) last_rdata = exp;
      if (we && !io) begin
        if (!mis) ref_store(a, sz, d);
        ew = ref_word(a);
        n_cmp++;
        if (ram[int'(a[11:2])] !== ew) begin
          n_bad++; $display("FAIL rand_ram[%0d]: a %h got %h required %h", i, a, ram[int'(a[11:2])], ew);
        end
      end else if (we && io && !mis) begin
        ew = (sz == 2'd0) ? (d & 32'hFF) : (sz == 2'd1) ? (d & 32'hFFFF) : d;
        n_cmp++;
        if (io_wr_data !== ew || io_wr_cnt != cnt0 + 1) begin
          n_bad++; $display("FAIL rand_io[%0d]: a %h got %h required %h", i, a, io_wr_data, ew);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int wes, vals; logic [31:0] w0;
    int lat, wc; logic [31:0] rd, as; logic er, rk;
    poke(32'h10, 32'h0BAD_F00D);
    w0 = 32'h0BAD_F00D;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_00C3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    wes = mem_we ? 1 : 0; vals = 0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_async: got we %b ready %b required 0 1", mem_we, req_ready);
    end
    repeat (3) begin
      @(negedge clk);
      if (mem_we) wes++;
      if (rsp_valid) vals++;
    end
    rst_n = 1'b1;
    last_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) wes++;
      if (rsp_valid) vals++;
    end
    n_cmp++;
    if (wes != 0 || vals != 0 || ram[4] !== w0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort: got we %0d rsp %0d word %h ready %b required 0 0 %h 1", wes, vals, ram[4], req_ready, w0);
    end
    n_cmp++;
    if (rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL abort_rdata: got %h required 00000000", rsp_rdata);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, wc, rd, er, as, rk);
    n_cmp++;
    if (rd !== 32'h0000_0BAD || lat != 2) begin
      n_bad++; $display("FAIL post_abort_lh: got %h lat %0d required 00000BAD lat 2", rd, lat);
    end
  endtask

  initial begin
    io_sw = '0;
    io_wr_data = '0;
    for (int i = 0; i < 1024; i++) poke(32'(i * 4), $urandom);
    test_reset();
    test_load_ext();
    test_rmw_store();
    test_io();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
